// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter and single-outstanding instruction
// memory requester. Resolves unconditional jumps locally, accepts taken-branch
// redirects, and carries a one-entry skid buffer so a decode stall never loses
// a returned word.
module instruction_fetch #(
  parameter int INSTR_BITS   = 32,
  parameter int OP_CODE_BITS = 6,
  parameter int ADDR_BITS    = 16,
  parameter int RESET_PC     = 0,
  parameter int JUMP_OPCODE  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [ADDR_BITS-1:0]    imem_addr,
  input  logic                    imem_valid,
  input  logic [INSTR_BITS-1:0]   imem_data,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDR_BITS-1:0]    redirect_addr,
  output logic                    instr_valid,
  output logic [OP_CODE_BITS-1:0] opcode,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [15:0]             imm,
  output logic [ADDR_BITS-1:0]    pc_out
);

  localparam logic [ADDR_BITS-1:0]    RESET_ADDR = ADDR_BITS'(RESET_PC);
  localparam logic [OP_CODE_BITS-1:0] JUMP_OP    = OP_CODE_BITS'(JUMP_OPCODE);
  localparam logic [ADDR_BITS-1:0]    PC_STEP    = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0]    ADDR_ZERO  = {ADDR_BITS{1'b0}};
  localparam logic [INSTR_BITS-1:0]   WORD_ZERO  = {INSTR_BITS{1'b0}};

  // FETCH issues a request, WAIT expects its response, HOLD parks a word in
  // the skid slot behind a stalled output, DROP swallows a response that a
  // redirect made stale.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_BITS-1:0]    pc_r;
  logic [ADDR_BITS-1:0]    pc_s;
  logic                    out_valid_r;
  logic                    out_valid_s;
  logic [INSTR_BITS-1:0]   out_word_r;
  logic [INSTR_BITS-1:0]   out_word_s;
  logic [ADDR_BITS-1:0]    out_pc_r;
  logic [ADDR_BITS-1:0]    out_pc_s;
  logic [INSTR_BITS-1:0]   skid_word_r;
  logic [INSTR_BITS-1:0]   skid_word_s;
  logic [ADDR_BITS-1:0]    skid_pc_r;
  logic [ADDR_BITS-1:0]    skid_pc_s;
  logic                    consumed_s;
  logic                    is_jump_s;
  logic [ADDR_BITS-1:0]    pc_inc_s;

  // Decode takes the presented word on any cycle it is live and not stalled.
  assign consumed_s = out_valid_r && !stall;
  assign is_jump_s  = (imem_data[INSTR_BITS-1 -: OP_CODE_BITS] == JUMP_OP);
  // Natural truncation gives the wrap from the top address back to zero.
  assign pc_inc_s   = pc_r + PC_STEP;

  // The request is a pure function of state so it goes out in the same cycle
  // the FSM enters FETCH; a redirect in that cycle cancels it.
  assign imem_req  = rst_n && !redirect && (state_r == FETCH);
  assign imem_addr = pc_r;

  assign instr_valid = out_valid_r;
  assign opcode      = out_word_r[INSTR_BITS-1 -: OP_CODE_BITS];
  assign rs          = out_word_r[25:21];
  assign rt          = out_word_r[20:16];
  assign rd          = out_word_r[15:11];
  assign imm         = out_word_r[15:0];
  assign pc_out      = out_pc_r;

  // Next-state and datapath update; redirect overrides every other event.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    out_valid_s = consumed_s ? 1'b0 : out_valid_r;
    out_word_s  = out_word_r;
    out_pc_s    = out_pc_r;
    skid_word_s = skid_word_r;
    skid_pc_s   = skid_pc_r;
    if (redirect) begin
      pc_s        = redirect_addr;
      out_valid_s = 1'b0;
      skid_word_s = WORD_ZERO;
      skid_pc_s   = ADDR_ZERO;
      case (state_r)
        FETCH:   state_s = FETCH;
        WAIT:    state_s = imem_valid ? FETCH : DROP;
        HOLD:    state_s = FETCH;
        DROP:    state_s = DROP;
        default: state_s = FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          state_s = WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            state_s = FETCH;
            if (is_jump_s) begin
              // Jumps never reach decode; only the PC moves.
              pc_s = imem_data[ADDR_BITS-1:0];
            end else if (!out_valid_r || !stall) begin
              out_valid_s = 1'b1;
              out_word_s  = imem_data;
              out_pc_s    = pc_r;
              pc_s        = pc_inc_s;
            end else begin
              skid_word_s = imem_data;
              skid_pc_s   = pc_r;
              pc_s        = pc_inc_s;
              state_s     = HOLD;
            end
          end else begin
            state_s = WAIT;
          end
        end
        HOLD: begin
          if (consumed_s) begin
            out_valid_s = 1'b1;
            out_word_s  = skid_word_r;
            out_pc_s    = skid_pc_r;
            state_s     = FETCH;
          end else begin
            state_s = HOLD;
          end
        end
        DROP: begin
          state_s = imem_valid ? FETCH : DROP;
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, output slot and skid slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r        <= RESET_ADDR;
      out_valid_r <= 1'b0;
      out_word_r  <= WORD_ZERO;
      out_pc_r    <= ADDR_ZERO;
      skid_word_r <= WORD_ZERO;
      skid_pc_r   <= ADDR_ZERO;
    end else begin
      pc_r        <= pc_s;
      out_valid_r <= out_valid_s;
      out_word_r  <= out_word_s;
      out_pc_r    <= out_pc_s;
      skid_word_r <= skid_word_s;
      skid_pc_r   <= skid_pc_s;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// stall/redirect/latency traffic, checked against a transaction-level model
// (expected fetch address plus a queue of instructions owed to decode).
module tb_instruction_fetch;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] word;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [15:0] pc_out;

  int errors = 0;
  int checks = 0;

  // sampled outputs of the current cycle
  logic        s_req;
  logic [15:0] s_addr;
  logic        s_valid;
  logic [5:0]  s_opcode;
  logic [4:0]  s_rs;
  logic [4:0]  s_rt;
  logic [4:0]  s_rd;
  logic [15:0] s_imm;
  logic [15:0] s_pc_out;

  // reference model / memory state
  ent_t        expq[$];
  logic [15:0] exp_fetch;
  bit          pending;
  bit          stale;
  logic [15:0] pend_addr;
  int          pend_cnt;
  int          lat_cfg;
  bit          prev_hold;
  bit          prev_redirect;
  logic [48:0] prev_snap;
  int          presented;
  bit          saw_pc5;
  logic [31:0] seed_word;
  logic [31:0] prog [logic [15:0]];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .imm           (imm),
    .pc_out        (pc_out)
  );

  // Memory contents: directed program words, otherwise a hashed word with
  // roughly one jump (opcode 15) in eight.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] h;
    if (prog.exists(a)) return prog[a];
    h = ({a, ~a} * 32'h9E3779B1) ^ seed_word;
    if (h[3:1] == 3'd0) h[31:26] = 6'd15;
    else if (h[31:26] == 6'd15) h[31:26] = 6'd14;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory side, sample outputs, run the model,
  // then advance to just after the next rising edge.
  task automatic step();
    bit          resp;
    ent_t        e;
    logic [31:0] w;
    logic [48:0] snap;
    resp       = 1'b0;
    imem_valid = 1'b0;
    imem_data  = $urandom;
    if (!rst_n) begin
      pending = 1'b0;
    end else if (pending) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_valid = 1'b1;
        imem_data  = mem_word(pend_addr);
        resp       = 1'b1;
      end
    end
    #1;
    s_req = imem_req;  s_addr = imem_addr;  s_valid = instr_valid;
    s_opcode = opcode; s_rs = rs; s_rt = rt; s_rd = rd; s_imm = imm;
    s_pc_out = pc_out;
    snap = {s_valid, s_opcode, s_rs, s_rt, s_imm, s_pc_out};
    if (!rst_n) begin
      chk("req_in_reset", s_req, 0);
      expq.delete();
      exp_fetch     = 16'h0000;
      pending       = 1'b0;
      stale         = 1'b0;
      prev_hold     = 1'b0;
      prev_redirect = 1'b0;
    end else begin
      if (prev_redirect) chk("redirect_flush", s_valid, 0);
      if (prev_hold) chk("stall_stable", snap, prev_snap);
      if (s_valid && !stall) begin
        presented++;
        if (s_pc_out == 16'h0005) saw_pc5 = 1'b1;
        if (expq.size() == 0) begin
          chk("present_expected", 0, 1);
        end else begin
          e = expq.pop_front();
          chk("present_pc", s_pc_out, e.pc);
          chk("present_word", {s_opcode, s_rs, s_rt, s_imm}, e.word);
          chk("present_rd", s_rd, e.word[15:11]);
        end
      end
      if (redirect) begin
        expq.delete();
        exp_fetch = redirect_addr;
        if (pending && !resp) stale = 1'b1;
      end
      if (resp) begin
        pending = 1'b0;
        if (!redirect && !stale) begin
          w = imem_data;
          if (w[31:26] == 6'd15) begin
            exp_fetch = w[15:0];
          end else begin
            e.pc   = pend_addr;
            e.word = w;
            expq.push_back(e);
            exp_fetch = pend_addr + 16'd1;
            chk("queue_depth", expq.size() <= 2, 1);
          end
        end
        stale = 1'b0;
      end
      if (s_req) begin
        chk("req_addr", s_addr, exp_fetch);
        chk("req_single", pending, 0);
        pending   = 1'b1;
        pend_addr = s_addr;
        pend_cnt  = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
        stale     = 1'b0;
      end
      prev_hold     = s_valid && stall && !redirect;
      prev_redirect = redirect;
      prev_snap     = snap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int bound);
    int n = 0;
    do begin step(); n++; end while (!s_req && n < bound);
    chk(tag, s_req, 1);
  endtask

  task automatic wait_addr(input string tag, input logic [15:0] a, input int bound);
    int n = 0;
    do begin step(); n++; end while (!(s_req && s_addr == a) && n < bound);
    chk(tag, s_req && (s_addr == a), 1);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [5:0] op, input logic [15:0] pc);
    chk({tag, "_valid"}, s_valid, v);
    chk({tag, "_opcode"}, s_opcode, op);
    chk({tag, "_pc"}, s_pc_out, pc);
  endtask

  initial begin
    int base;
    seed_word = $urandom;
    prog[16'h0000] = {6'd1, 5'd1, 5'd2, 16'h0005};
    prog[16'h0001] = {6'd2, 5'd3, 5'd4, 5'd5, 11'd0};
    prog[16'h0002] = {6'd3, 26'h0000123};
    prog[16'h0003] = {6'd3, 26'h0000456};
    prog[16'h0004] = {6'd3, 26'h0000789};
    prog[16'h0005] = {6'd15, 10'd0, 16'h0040};
    prog[16'h0040] = {6'd4, 5'd6, 5'd7, 16'hABCD};
    prog[16'h0041] = {6'd5, 5'd8, 5'd9, 16'h1357};
    prog[16'h0042] = {6'd6, 26'h0000042};
    prog[16'h0100] = {6'd8, 26'h0000100};
    prog[16'h0200] = {6'd9, 26'h0000200};
    prog[16'h0201] = {6'd10, 26'h0000201};
    prog[16'hFFFF] = {6'd7, 5'd31, 5'd30, 16'hFEED};
    pending = 1'b0; stale = 1'b0; prev_hold = 1'b0; prev_redirect = 1'b0;
    exp_fetch = 16'h0000; presented = 0; saw_pc5 = 1'b0; lat_cfg = 1;
    prev_snap = 49'd0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
    imem_valid = 1'b0; imem_data = 32'h0;
    @(posedge clk);
    #1;

    // Reset state
    step(); step();
    chk_out("rst", 1'b0, 6'd0, 16'h0000);
    chk("rst_rs", s_rs, 0); chk("rst_rt", s_rt, 0);
    chk("rst_rd", s_rd, 0); chk("rst_imm", s_imm, 0);

    // Release: request at 0 in cycle 1, addi presented in cycle 3, sub in cycle 5
    rst_n = 1'b1;
    step(); chk("c1_req", s_req, 1); chk("c1_addr", s_addr, 16'h0000);
    step(); chk("c2_req", s_req, 0);
    step(); chk_out("c3", 1'b1, 6'd1, 16'h0000); chk("c3_addr", s_addr, 16'h0001);
    step(); step(); chk_out("c5", 1'b1, 6'd2, 16'h0001);

    // Jump at address 5 is resolved locally
    wait_addr("reach_addr5", 16'h0005, 30);
    wait_req("jump_next_req", 10);
    chk("jump_target", s_addr, 16'h0040);

    // Stall 6 cycles while the next response lands in the skid slot
    step();
    stall = 1'b1;
    step(); chk_out("stall0", 1'b1, 6'd4, 16'h0040); chk("stall0_addr", s_addr, 16'h0041);
    for (int i = 0; i < 5; i++) begin
      step(); chk_out("stall_n", 1'b1, 6'd4, 16'h0040); chk("hold_noreq", s_req, 0);
    end
    stall = 1'b0;
    step(); chk_out("release", 1'b1, 6'd4, 16'h0040); chk("release_req", s_req, 0);
    stall = 1'b1; lat_cfg = 3;
    step(); chk_out("skid_out", 1'b1, 6'd5, 16'h0041);
    chk("resume_req", s_req, 1); chk("resume_addr", s_addr, 16'h0042);
    chk("jump_hidden", saw_pc5, 0);

    // Redirect in WAIT with a 3-cycle memory: late response dropped
    redirect = 1'b1; redirect_addr = 16'h0100;
    step(); chk("rw_req", s_req, 0);
    redirect = 1'b0; stall = 1'b0;
    step(); chk("rw_valid", s_valid, 0); chk("rw_req1", s_req, 0);
    step(); chk("rw_drop_req", s_req, 0);
    lat_cfg = 1;
    step(); chk("rw_target_req", s_req, 1); chk("rw_target", s_addr, 16'h0100);

    // Redirect coinciding with imem_valid
    redirect = 1'b1; redirect_addr = 16'h0200;
    step();
    redirect = 1'b0;
    step(); chk("rv_valid", s_valid, 0); chk("rv_req", s_req, 1); chk("rv_addr", s_addr, 16'h0200);

    // Redirect while stalled with a word in the skid slot
    step();
    stall = 1'b1;
    step(); chk_out("rs_out", 1'b1, 6'd9, 16'h0200);
    step();
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    step(); chk("rs_hold_req", s_req, 0); chk("rs_hold_valid", s_valid, 1);
    redirect = 1'b0; stall = 1'b0;
    step(); chk("rs_valid", s_valid, 0); chk("rs_req", s_req, 1); chk("rs_addr", s_addr, 16'hFFFF);

    // PC wrap from 0xFFFF to 0x0000
    step();
    lat_cfg = 3;
    step(); chk_out("wrap", 1'b1, 6'd7, 16'hFFFF); chk("wrap_req", s_req, 1);
    chk("wrap_addr", s_addr, 16'h0000);

    // Reset asserted during WAIT
    rst_n = 1'b0;
    step(); step();
    chk_out("mrst", 1'b0, 6'd0, 16'h0000); chk("mrst_imm", s_imm, 0); chk("mrst_rd", s_rd, 0);
    rst_n = 1'b1;
    step(); chk("mrst_req", s_req, 1); chk("mrst_addr", s_addr, 16'h0000);

    // Randomized traffic against the model
    lat_cfg = 0;
    base = presented;
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 499) != 0);
      stall         = ($urandom_range(0, 99) < 35);
      redirect      = ($urandom_range(0, 99) < 4);
      redirect_addr = 16'($urandom);
      step();
    end
    chk("random_progress", (presented - base) > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
